// File: rtl/mp_coherence_ctrl.sv
// Multi-processor memory/coherence controller: arbitrates icache fetches, dcache
// writebacks and snooped coherence misses from CPUS caches onto one RAM port.
package mp_coherence_pkg;
    typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
endpackage

module mp_coherence_ctrl
    import mp_coherence_pkg::*;
#(
    parameter int CPUS  = 2,
    parameter int WORDS = 2
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [CPUS-1:0]            iREN,
    input  logic [CPUS-1:0][31:0]      iaddr,
    input  logic [CPUS-1:0]            dREN,
    input  logic [CPUS-1:0]            dWEN,
    input  logic [CPUS-1:0][31:0]      daddr,
    input  logic [CPUS-1:0][31:0]      dstore,
    input  logic [CPUS-1:0]            ccwrite,
    input  logic [CPUS-1:0]            cctrans,
    output logic [CPUS-1:0]            iwait,
    output logic [CPUS-1:0]            dwait,
    output logic [CPUS-1:0][31:0]      iload,
    output logic [CPUS-1:0][31:0]      dload,
    output logic [CPUS-1:0]            ccwait,
    output logic [CPUS-1:0]            ccinv,
    output logic [CPUS-1:0][31:0]      ccsnoopaddr,
    output logic                       ramREN,
    output logic                       ramWEN,
    output logic [31:0]                ramaddr,
    output logic [31:0]                ramstore,
    input  logic [31:0]                ramload,
    input  ramstate_t                  ramstate
);
    localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int CW = $clog2(WORDS) + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0, IFETCH = 3'd1, WB = 3'd2, SNOOP = 3'd3, FWD = 3'd4, RAMRD = 3'd5
    } state_t;

    state_t                 state_r, state_s;
    logic [IW-1:0]          g_r, g_s, s_r, s_s, rr_r, rr_s;
    logic [CW-1:0]          cnt_r, cnt_s;
    logic                   inv_r, inv_s;
    logic                   acc_s, last_s;
    logic [IW:0]            wb_pick_s, sn_pick_s, if_pick_s, sup_pick_s;
    logic [CPUS-1:0]        others_s;
    logic [CPUS-1:0][31:0]  snaddr_s;

    // First requester at or after ptr, wrapping; MSB of the result flags a hit.
    function automatic logic [IW:0] rr_pick(input logic [CPUS-1:0] req, input logic [IW-1:0] ptr);
        logic [IW:0] res;
        int          idx;
        res = '0;
        for (int k = CPUS - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % CPUS;
            if (req[idx]) res = {1'b1, IW'(idx)};
        end
        return res;
    endfunction

    // Lowest-index cache other than the requester that holds the block Modified.
    function automatic logic [IW:0] sup_pick(input logic [CPUS-1:0] modified, input logic [IW-1:0] req);
        logic [IW:0] res;
        res = '0;
        for (int j = CPUS - 1; j >= 0; j--) begin
            if (modified[j] && (j != int'(req))) res = {1'b1, IW'(j)};
        end
        return res;
    endfunction

    function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] grant);
        return IW'((int'(grant) + 1) % CPUS);
    endfunction

    assign acc_s  = (ramstate == ACCESS);
    assign last_s = (cnt_r == CW'(WORDS - 1));

    // State, grant, supplier, round-robin pointer and word counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= IDLE;
            g_r     <= '0;
            s_r     <= '0;
            rr_r    <= '0;
            cnt_r   <= '0;
            inv_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            g_r     <= g_s;
            s_r     <= s_s;
            rr_r    <= rr_s;
            cnt_r   <= cnt_s;
            inv_r   <= inv_s;
        end
    end

    // Arbitration and next-state logic; BUSY/ERROR leave everything unchanged.
    always_comb begin
        state_s    = state_r;
        g_s        = g_r;
        s_s        = s_r;
        rr_s       = rr_r;
        cnt_s      = cnt_r;
        inv_s      = inv_r;
        wb_pick_s  = rr_pick(dWEN & ~cctrans, rr_r);
        sn_pick_s  = rr_pick(dREN & cctrans, rr_r);
        if_pick_s  = rr_pick(iREN, rr_r);
        sup_pick_s = sup_pick(ccwrite, g_r);
        case (state_r)
            IDLE: begin
                cnt_s = '0;
                if (wb_pick_s[IW]) begin
                    state_s = WB;
                    g_s     = wb_pick_s[IW-1:0];
                    rr_s    = rr_next(wb_pick_s[IW-1:0]);
                end else if (sn_pick_s[IW]) begin
                    state_s = SNOOP;
                    g_s     = sn_pick_s[IW-1:0];
                    rr_s    = rr_next(sn_pick_s[IW-1:0]);
                end else if (if_pick_s[IW]) begin
                    state_s = IFETCH;
                    g_s     = if_pick_s[IW-1:0];
                    rr_s    = rr_next(if_pick_s[IW-1:0]);
                end else begin
                    state_s = IDLE;
                end
            end
            IFETCH: state_s = acc_s ? IDLE : IFETCH;
            SNOOP: begin
                inv_s   = ccwrite[g_r];
                s_s     = sup_pick_s[IW-1:0];
                state_s = sup_pick_s[IW] ? FWD : RAMRD;
            end
            WB, FWD, RAMRD: begin
                if (acc_s && last_s) begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end else if (acc_s) begin
                    cnt_s = cnt_r + CW'(1);
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Output decode: every wait stays high except on the cycle its word completes.
    always_comb begin
        iwait       = '1;
        dwait       = '1;
        iload       = '0;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = 32'h0;
        ramstore    = 32'h0;
        for (int j = 0; j < CPUS; j++) begin
            others_s[j] = (j != int'(g_r));
            snaddr_s[j] = (j != int'(g_r)) ? daddr[g_r] : 32'h0;
        end
        case (state_r)
            IFETCH: begin
                ramREN      = 1'b1;
                ramaddr     = iaddr[g_r];
                iload[g_r]  = acc_s ? ramload : 32'h0;
                iwait[g_r]  = ~acc_s;
            end
            WB: begin
                ramWEN      = 1'b1;
                ramaddr     = daddr[g_r];
                ramstore    = dstore[g_r];
                dwait[g_r]  = ~acc_s;
            end
            SNOOP: begin
                ccwait      = others_s;
                ccinv       = others_s & {CPUS{ccwrite[g_r]}};
                ccsnoopaddr = snaddr_s;
            end
            FWD: begin
                ccwait[s_r]      = 1'b1;
                ccinv[s_r]       = inv_r;
                ccsnoopaddr[s_r] = daddr[g_r];
                ramWEN           = 1'b1;
                ramaddr          = daddr[s_r];
                ramstore         = dstore[s_r];
                dload[g_r]       = dstore[s_r];
                dwait[g_r]       = ~acc_s;
                dwait[s_r]       = ~acc_s;
            end
            RAMRD: begin
                ccwait      = others_s;
                ccinv       = others_s & {CPUS{inv_r}};
                ccsnoopaddr = snaddr_s;
                ramREN      = 1'b1;
                ramaddr     = daddr[g_r];
                dload[g_r]  = acc_s ? ramload : 32'h0;
                dwait[g_r]  = ~acc_s;
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_mp_coherence_ctrl.sv
// Directed bench for mp_coherence_ctrl: a two-CPU instance driven from a vector
// table plus hand sequences, and a four-CPU instance for the invalidate case.
module tb_mp_coherence_ctrl;
    import mp_coherence_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] ramload;
    ramstate_t   ramstate;
    always #5 CLK = ~CLK;

    logic [1:0]       iren2, dren2, dwen2, cct2, ccw2, iwait2, dwait2, ccwait2, ccinv2;
    logic [1:0][31:0] iaddr2, daddr2, dstore2, iload2, dload2, csa2;
    logic             ren2, wen2;
    logic [31:0]      raddr2, rstore2;

    logic [3:0]       iren4, dren4, dwen4, cct4, ccw4, iwait4, dwait4, ccwait4, ccinv4;
    logic [3:0][31:0] iaddr4, daddr4, dstore4, iload4, dload4, csa4;
    logic             ren4, wen4;
    logic [31:0]      raddr4, rstore4;

    mp_coherence_ctrl #(.CPUS(2), .WORDS(2)) dut2 (
        .CLK(CLK), .nRST(nRST), .iREN(iren2), .iaddr(iaddr2), .dREN(dren2), .dWEN(dwen2),
        .daddr(daddr2), .dstore(dstore2), .ccwrite(ccw2), .cctrans(cct2), .iwait(iwait2),
        .dwait(dwait2), .iload(iload2), .dload(dload2), .ccwait(ccwait2), .ccinv(ccinv2),
        .ccsnoopaddr(csa2), .ramREN(ren2), .ramWEN(wen2), .ramaddr(raddr2), .ramstore(rstore2),
        .ramload(ramload), .ramstate(ramstate));

    mp_coherence_ctrl #(.CPUS(4), .WORDS(2)) dut4 (
        .CLK(CLK), .nRST(nRST), .iREN(iren4), .iaddr(iaddr4), .dREN(dren4), .dWEN(dwen4),
        .daddr(daddr4), .dstore(dstore4), .ccwrite(ccw4), .cctrans(cct4), .iwait(iwait4),
        .dwait(dwait4), .iload(iload4), .dload(dload4), .ccwait(ccwait4), .ccinv(ccinv4),
        .ccsnoopaddr(csa4), .ramREN(ren4), .ramWEN(wen4), .ramaddr(raddr4), .ramstore(rstore4),
        .ramload(ramload), .ramstate(ramstate));

    typedef struct {
        logic [1:0]  iren, dren, dwen, cct, ccw;
        logic [31:0] a0, a1, st1;
        ramstate_t   rs;
        logic [31:0] rl;
        logic [1:0]  e_iwait, e_dwait, e_ccwait, e_ccinv;
        logic        e_ren, e_wen;
        logic [31:0] e_raddr, e_rstore;
        logic [63:0] e_iload, e_dload, e_csa;
    } vec_t;

    localparam int NV = 16;
    vec_t vt [NV];
    int   total = 0;
    int   bad   = 0;
    int   comps;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic zero_inputs();
        iren2 = '0; dren2 = '0; dwen2 = '0; cct2 = '0; ccw2 = '0;
        iaddr2 = '0; daddr2 = '0; dstore2 = '0;
        iren4 = '0; dren4 = '0; dwen4 = '0; cct4 = '0; ccw4 = '0;
        iaddr4 = '0; daddr4 = '0; dstore4 = '0;
        ramstate = FREE; ramload = 32'h0;
    endtask

    task automatic chk_reset4(input string tag);
        chk({tag, " iwait4"}, 128'(iwait4), 128'(4'b1111));
        chk({tag, " dwait4"}, 128'(dwait4), 128'(4'b1111));
        chk({tag, " ccwait4"}, 128'(ccwait4), 128'(4'b0000));
        chk({tag, " ccinv4"}, 128'(ccinv4), 128'(4'b0000));
        chk({tag, " ram4"}, 128'({ren4, wen4, raddr4, rstore4}), 128'd0);
        chk({tag, " loads4"}, 128'(dload4) | 128'(iload4) | 128'(csa4), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //          iren  dren  dwen  cct   ccw   a0          a1          st1           rs      rl            iwait dwait ccwt  ccinv ren   wen   raddr       rstore        iload                   dload                   csa
        vt[0]  = '{2'b10,2'b00,2'b00,2'b00,2'b00,32'h0,      32'h40,     32'h0,        FREE,   32'h0,        2'b11,2'b11,2'b00,2'b00,1'b0,1'b0,32'h0,      32'h0,        64'h0,                  64'h0,                  64'h0};
        vt[1]  = '{2'b10,2'b00,2'b00,2'b00,2'b00,32'h0,      32'h40,     32'h0,        BUSY,   32'h0,        2'b11,2'b11,2'b00,2'b00,1'b1,1'b0,32'h40,     32'h0,        64'h0,                  64'h0,                  64'h0};
        vt[2]  = '{2'b10,2'b00,2'b00,2'b00,2'b00,32'h0,      32'h40,     32'h0,        ERROR,  32'h0,        2'b11,2'b11,2'b00,2'b00,1'b1,1'b0,32'h40,     32'h0,        64'h0,                  64'h0,                  64'h0};
        vt[3]  = '{2'b10,2'b00,2'b00,2'b00,2'b00,32'h0,      32'h40,     32'h0,        ACCESS, 32'hDEAD,     2'b01,2'b11,2'b00,2'b00,1'b1,1'b0,32'h40,     32'h0,        64'h0000DEAD_00000000,  64'h0,                  64'h0};
        vt[4]  = '{2'b00,2'b00,2'b00,2'b00,2'b00,32'h0,      32'h40,     32'h0,        FREE,   32'h0,        2'b11,2'b11,2'b00,2'b00,1'b0,1'b0,32'h0,      32'h0,        64'h0,                  64'h0,                  64'h0};
        vt[5]  = '{2'b01,2'b00,2'b10,2'b00,2'b00,32'h300,    32'h80,     32'hAAAA0001, FREE,   32'h0,        2'b11,2'b11,2'b00,2'b00,1'b0,1'b0,32'h0,      32'h0,        64'h0,                  64'h0,                  64'h0};
        vt[6]  = '{2'b01,2'b00,2'b10,2'b00,2'b00,32'h300,    32'h80,     32'hAAAA0001, ACCESS, 32'h0,        2'b11,2'b01,2'b00,2'b00,1'b0,1'b1,32'h80,     32'hAAAA0001, 64'h0,                  64'h0,                  64'h0};
        vt[7]  = '{2'b01,2'b00,2'b10,2'b00,2'b00,32'h300,    32'h84,     32'hAAAA0002, ACCESS, 32'h0,        2'b11,2'b01,2'b00,2'b00,1'b0,1'b1,32'h84,     32'hAAAA0002, 64'h0,                  64'h0,                  64'h0};
        vt[8]  = '{2'b01,2'b00,2'b00,2'b00,2'b00,32'h300,    32'h84,     32'h0,        FREE,   32'h0,        2'b11,2'b11,2'b00,2'b00,1'b0,1'b0,32'h0,      32'h0,        64'h0,                  64'h0,                  64'h0};
        vt[9]  = '{2'b01,2'b00,2'b00,2'b00,2'b00,32'h300,    32'h84,     32'h0,        ACCESS, 32'h1234,     2'b10,2'b11,2'b00,2'b00,1'b1,1'b0,32'h300,    32'h0,        64'h00000000_00001234,  64'h0,                  64'h0};
        vt[10] = '{2'b00,2'b00,2'b00,2'b00,2'b00,32'h0,      32'h0,      32'h0,        FREE,   32'h0,        2'b11,2'b11,2'b00,2'b00,1'b0,1'b0,32'h0,      32'h0,        64'h0,                  64'h0,                  64'h0};
        vt[11] = '{2'b00,2'b01,2'b00,2'b01,2'b10,32'h100,    32'h0,      32'h0,        FREE,   32'h0,        2'b11,2'b11,2'b00,2'b00,1'b0,1'b0,32'h0,      32'h0,        64'h0,                  64'h0,                  64'h0};
        vt[12] = '{2'b00,2'b01,2'b00,2'b01,2'b10,32'h100,    32'h0,      32'h0,        FREE,   32'h0,        2'b11,2'b11,2'b10,2'b00,1'b0,1'b0,32'h0,      32'h0,        64'h0,                  64'h0,                  64'h00000100_00000000};
        vt[13] = '{2'b00,2'b01,2'b10,2'b01,2'b10,32'h100,    32'h100,    32'h11,       ACCESS, 32'h0,        2'b11,2'b00,2'b10,2'b00,1'b0,1'b1,32'h100,    32'h11,       64'h0,                  64'h00000000_00000011,  64'h00000100_00000000};
        vt[14] = '{2'b00,2'b01,2'b10,2'b01,2'b10,32'h104,    32'h104,    32'h22,       ACCESS, 32'h0,        2'b11,2'b00,2'b10,2'b00,1'b0,1'b1,32'h104,    32'h22,       64'h0,                  64'h00000000_00000022,  64'h00000104_00000000};
        vt[15] = '{2'b00,2'b00,2'b00,2'b00,2'b00,32'h0,      32'h0,      32'h0,        FREE,   32'h0,        2'b11,2'b11,2'b00,2'b00,1'b0,1'b0,32'h0,      32'h0,        64'h0,                  64'h0,                  64'h0};

        // Reset held with random stimulus on both instances.
        nRST = 1'b0;
        zero_inputs();
        repeat (3) begin
            @(negedge CLK);
            iren2 = 2'($urandom); dren2 = 2'($urandom); dwen2 = 2'($urandom);
            cct2 = 2'($urandom); ccw2 = 2'($urandom);
            iaddr2 = {$urandom, $urandom}; daddr2 = {$urandom, $urandom}; dstore2 = {$urandom, $urandom};
            dren4 = 4'($urandom); cct4 = 4'($urandom); ccw4 = 4'($urandom);
            ramload = $urandom; ramstate = ramstate_t'(2'($urandom_range(0, 3)));
            #1;
            chk("rst iwait2", 128'(iwait2), 128'(2'b11));
            chk("rst dwait2", 128'(dwait2), 128'(2'b11));
            chk("rst cc2", 128'({ccwait2, ccinv2}), 128'(4'b0000));
            chk("rst ram2", 128'({ren2, wen2, raddr2, rstore2}), 128'd0);
            chk("rst loads2", 128'(iload2) | 128'(dload2) | 128'(csa2), 128'd0);
            chk_reset4("rst");
        end
        @(negedge CLK);
        zero_inputs();
        nRST = 1'b1;
        #1;
        chk("post-rst ram2", 128'({ren2, wen2}), 128'(2'b00));

        // Table: fetch with stalls, writeback priority, cache-to-cache forward.
        for (int i = 0; i < NV; i++) begin
            @(negedge CLK);
            iren2 = vt[i].iren; dren2 = vt[i].dren; dwen2 = vt[i].dwen;
            cct2 = vt[i].cct; ccw2 = vt[i].ccw;
            iaddr2[0] = vt[i].a0; daddr2[0] = vt[i].a0;
            iaddr2[1] = vt[i].a1; daddr2[1] = vt[i].a1;
            dstore2[0] = 32'h0; dstore2[1] = vt[i].st1;
            ramstate = vt[i].rs; ramload = vt[i].rl;
            #1;
            chk($sformatf("v%0d iwait", i), 128'(iwait2), 128'(vt[i].e_iwait));
            chk($sformatf("v%0d dwait", i), 128'(dwait2), 128'(vt[i].e_dwait));
            chk($sformatf("v%0d ccwait", i), 128'(ccwait2), 128'(vt[i].e_ccwait));
            chk($sformatf("v%0d ccinv", i), 128'(ccinv2), 128'(vt[i].e_ccinv));
            chk($sformatf("v%0d ramREN", i), 128'(ren2), 128'(vt[i].e_ren));
            chk($sformatf("v%0d ramWEN", i), 128'(wen2), 128'(vt[i].e_wen));
            chk($sformatf("v%0d ramaddr", i), 128'(raddr2), 128'(vt[i].e_raddr));
            chk($sformatf("v%0d ramstore", i), 128'(rstore2), 128'(vt[i].e_rstore));
            chk($sformatf("v%0d iload", i), 128'(iload2), 128'(vt[i].e_iload));
            chk($sformatf("v%0d dload", i), 128'(dload2), 128'(vt[i].e_dload));
            chk($sformatf("v%0d snoopaddr", i), 128'(csa2), 128'(vt[i].e_csa));
        end

        // Round-robin: both icaches requesting, RAM always ready, pointer reset to 0.
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        nRST = 1'b1;
        iren2 = 2'b11; iaddr2[0] = 32'h2000; iaddr2[1] = 32'h1000;
        ramstate = ACCESS; ramload = 32'hF00D;
        comps = 0;
        for (int c = 0; c < 20 && comps < 4; c++) begin
            @(negedge CLK);
            #1;
            if (iwait2 != 2'b11) begin
                chk($sformatf("rr grant %0d", comps), 128'(iwait2), 128'(comps[0] ? 2'b01 : 2'b10));
                chk($sformatf("rr addr %0d", comps), 128'(raddr2), 128'(comps[0] ? 32'h1000 : 32'h2000));
                comps++;
            end
        end
        chk("rr completions", 128'(comps), 128'd4);
        zero_inputs();

        // Four CPUs: BusRdX from CPU2 with no Modified holder, reset mid-block.
        @(negedge CLK);
        dren4 = 4'b0100; cct4 = 4'b0100; ccw4 = 4'b0100; daddr4[2] = 32'h200;
        #1;
        chk("inv idle", 128'({ccwait4, ren4}), 128'd0);
        @(negedge CLK);
        #1;
        chk("inv snoop ccwait", 128'(ccwait4), 128'(4'b1011));
        chk("inv snoop ccinv", 128'(ccinv4), 128'(4'b1011));
        chk("inv snoop addr", 128'(csa4), 128'h00000200_00000000_00000200_00000200);
        chk("inv snoop dwait", 128'(dwait4), 128'(4'b1111));
        ramstate = ACCESS; ramload = 32'h77;
        @(negedge CLK);
        #1;
        chk("inv rd0 ren", 128'({ren4, wen4, raddr4}), 128'({1'b1, 1'b0, 32'h200}));
        chk("inv rd0 dload", 128'(dload4), 128'h00000000_00000077_00000000_00000000);
        chk("inv rd0 dwait", 128'(dwait4), 128'(4'b1011));
        chk("inv rd0 cc", 128'({ccwait4, ccinv4}), 128'(8'b1011_1011));
        daddr4[2] = 32'h204; ramstate = BUSY;
        @(negedge CLK);
        #1;
        chk("inv rd1 stall", 128'({ren4, raddr4, dwait4}), 128'({1'b1, 32'h204, 4'b1111}));
        chk("inv rd1 ccinv", 128'(ccinv4), 128'(4'b1011));
        nRST = 1'b0;
        #1;
        chk_reset4("midrst");
        zero_inputs();
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        #1;
        chk("inv after rst", 128'({ren4, wen4, ccwait4}), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
